// File: rtl/counter_monitor.sv
// Passive sequence checker for a free-running counter bus: locks onto an
// incrementing stream, flags breaks and keeps saturating error/wrap statistics.
module counter_monitor #(
  parameter int WIDTH       = 5,
  parameter int LOCK_THRESH = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             valid,
  input  logic             clear,
  output logic             locked,
  output logic             mismatch,
  output logic             error_sticky,
  output logic [ERR_W-1:0] error_count,
  output logic [ERR_W-1:0] wrap_count,
  output logic [WIDTH-1:0] expected
);

  // state  | meaning
  // HUNT   | no reference yet; next valid sample seeds the sequence
  // SYNC   | acquiring; counting consecutive in-sequence samples
  // LOCKED | sequence confirmed; breaks are reported as mismatches
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]       THRESH   = 4'(LOCK_THRESH);
  localparam logic [3:0]       RUN_MAX  = 4'hF;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [ERR_W-1:0] CNT_MAX  = '1;

  state_t           state, state_nxt;
  logic [3:0]       run, run_nxt, run_inc;
  logic [WIDTH-1:0] expected_nxt, seed_nxt;
  logic [ERR_W-1:0] error_count_nxt, wrap_count_nxt;
  logic             mismatch_nxt, error_sticky_nxt;
  logic             hit;

  assign seed_nxt = count_in + WIDTH'(1);
  assign run_inc  = (run == RUN_MAX) ? run : run + 4'd1;
  assign hit      = (count_in == expected);

  always_comb begin
    state_nxt        = state;
    run_nxt          = run;
    expected_nxt     = expected;
    error_count_nxt  = error_count;
    wrap_count_nxt   = wrap_count;
    error_sticky_nxt = error_sticky;
    mismatch_nxt     = 1'b0;

    if (clear) begin
      state_nxt        = HUNT;
      run_nxt          = 4'd0;
      expected_nxt     = '0;
      error_count_nxt  = '0;
      wrap_count_nxt   = '0;
      error_sticky_nxt = 1'b0;
    end else if (valid) begin
      case (state)
        HUNT: begin
          expected_nxt = seed_nxt;
          run_nxt      = 4'd1;
          state_nxt    = (THRESH == 4'd1) ? LOCKED : SYNC;
        end

        SYNC: begin
          if (hit) begin
            expected_nxt = expected + WIDTH'(1);
            run_nxt      = run_inc;
            if (run_inc == THRESH) state_nxt = LOCKED;
          end else begin
            // Still acquiring: reseed silently rather than flagging an error.
            expected_nxt = seed_nxt;
            run_nxt      = 4'd1;
          end
        end

        LOCKED: begin
          if (hit) begin
            expected_nxt = expected + WIDTH'(1);
            run_nxt      = run_inc;
            if (count_in == ALL_ONES && wrap_count != CNT_MAX)
              wrap_count_nxt = wrap_count + ERR_W'(1);
          end else begin
            mismatch_nxt     = 1'b1;
            error_sticky_nxt = 1'b1;
            if (error_count != CNT_MAX)
              error_count_nxt = error_count + ERR_W'(1);
            expected_nxt = seed_nxt;
            run_nxt      = 4'd1;
            state_nxt    = (THRESH == 4'd1) ? LOCKED : SYNC;
          end
        end

        default: begin
          state_nxt = HUNT;
          run_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= HUNT;
      run          <= 4'd0;
      expected     <= '0;
      mismatch     <= 1'b0;
      error_sticky <= 1'b0;
      error_count  <= '0;
      wrap_count   <= '0;
    end else begin
      state        <= state_nxt;
      run          <= run_nxt;
      expected     <= expected_nxt;
      mismatch     <= mismatch_nxt;
      error_sticky <= error_sticky_nxt;
      error_count  <= error_count_nxt;
      wrap_count   <= wrap_count_nxt;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: doc/counter_monitor.md
Name: counter_monitor

Overview:
- Passive checker at the observing end of the free-running counter's count bus.
- Samples the count stream, locks onto the sequence and verifies that each sample is the previous value plus one, modulo 2^WIDTH.
- Flags every sequence break and keeps error and wrap statistics.
- Sits beside the counter DUT in the counter testbench; Ruby-VPI code reads its status outputs and never drives the count bus.

Parameters:
- WIDTH, 5, width of the observed count bus.
- LOCK_THRESH, 4, consecutive in-sequence samples needed to declare lock; legal range 1..15.
- ERR_W, 8, width of the saturating error and wrap counters.

Ports:
- clock  input  1  sampling clock, same clock as the counter.
- reset  input  1  asynchronous, active-low reset.
- count_in  input  WIDTH  observed counter value.
- valid  input  1  count_in is sampled only on a rising clock edge with valid=1.
- clear  input  1  synchronous clear of state and statistics; has priority over valid.
- locked  output  1  high while in LOCKED.
- mismatch  output  1  one-cycle pulse per out-of-sequence sample taken while LOCKED.
- error_sticky  output  1  set by any mismatch; cleared only by reset or clear.
- error_count  output  ERR_W  number of mismatches, saturating at all-ones.
- wrap_count  output  ERR_W  number of in-sequence wraps from all-ones to zero, saturating.
- expected  output  WIDTH  next value the monitor expects.

Behaviour:
- States are HUNT, SYNC and LOCKED, plus an internal 4-bit run counter that saturates.
- Reset is asynchronous on reset=0 and takes effect immediately, including mid-lock:
  - state=HUNT, run=0, expected=0;
  - locked=0, mismatch=0, error_sticky=0, error_count=0, wrap_count=0.
- All outputs are registered. Each updates on the edge that takes the sample and is visible in the following cycle. Latency is 1 clock.
- clear=1 at an edge has the same effect as reset. If valid is also 1 on that edge, the sample is discarded.
- valid=0: no state or counter changes; mismatch=0.
- mismatch defaults to 0 every cycle and is set only as described under LOCKED.
- HUNT, on valid:
  - expected <= count_in+1 (mod 2^WIDTH), run <= 1;
  - go to LOCKED if LOCK_THRESH==1, otherwise go to SYNC.
- SYNC, on valid with count_in==expected:
  - expected <= expected+1, run <= run+1;
  - when run+1 == LOCK_THRESH, go to LOCKED.
- SYNC, on valid with count_in!=expected:
  - expected <= count_in+1, run <= 1, remain in SYNC;
  - no error is flagged (still acquiring).
- LOCKED, on valid with count_in==expected:
  - expected <= expected+1;
  - if count_in is all-ones, wrap_count increments (saturating).
- LOCKED, on valid with count_in!=expected:
  - mismatch=1 for exactly one cycle, error_sticky <= 1, error_count increments (saturating);
  - expected <= count_in+1, run <= 1, go to SYNC, so locked falls.
  - If LOCK_THRESH==1, go back to LOCKED instead and locked stays high.
- Wrap rules:
  - Wraps are counted only in LOCKED, on a matching sample.
  - A wrap seen while in SYNC or HUNT is not counted.
- Arithmetic:
  - All expected arithmetic is WIDTH bits and wraps naturally; all-ones+1 = 0 is in sequence.
  - Counters hold at 2^ERR_W-1 and never roll over.
- A repeated value while LOCKED (e.g. the counter held, or in its own reset) is a mismatch.
- locked == (state==LOCKED) at all times.

Test Plan:
1. Reset released; count_in=0,1,2,3,... with valid=1 every cycle (LOCK_THRESH=4):
   - locked rises the cycle after the sample of 3;
   - mismatch never pulses; expected tracks count_in+1.
2. While locked, feed 30,31,0,1:
   - wrap_count goes 0->1 after the sample of 0 is expected and 31 matches;
   - error_count stays 0.
3. Locked with expected=10, feed 12:
   - mismatch high exactly one cycle; error_count=1, error_sticky=1, locked=0, expected=13;
   - then feed 13,14,15: locked rises after 15;
   - error_sticky stays 1.
4. Locked, toggle valid 1,0,0,1 with count_in jumping while valid=0:
   - no mismatch; the sequence continues only on valid samples.
5. ERR_W=2, force 5 mismatches in LOCKED, relocking between each:
   - error_count reads 1,2,3,3,3;
   - wrap_count saturation is checked the same way.
6. Control precedence:
   - clear=1 together with valid and a bad value: all outputs zero, state HUNT, no mismatch.
   - Assert reset low asynchronously mid-cycle while locked: outputs clear immediately.
   - After reset is released, relock from an arbitrary start value (e.g. 17).
